ppu_op_sequencer: RTL

Parametrised issue/complete sequencer for the PPU datapath.
- Accepts tagged operations over a valid/ready handshake and tracks up to MAX_INFLIGHT outstanding operations, each with its own per-op latency.
- Returns completions strictly in issue order, with a registered-occupancy backpressure path.
- Replaces the single-op enable-driven latency FSM: adds configurable latencies, multiple in-flight ops, output stall and illegal-op reporting.

---
 rtl/ppu_op_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/ppu_op_sequencer.sv
// ppu_op_sequencer: in-order issue/complete scoreboard with per-op latency and illegal-op reporting.
// Define FLOAT_CONV_EN to make FLOAT_TO_POSIT/POSIT_TO_FLOAT legal ops with LAT_CONV latency.
module ppu_op_sequencer #(
  parameter int OP_SIZE      = 3,
  parameter int TAG_W        = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int LAT_ADD      = 2,
  parameter int LAT_MUL      = 2,
  parameter int LAT_DIV      = 3,
  parameter int LAT_CONV     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_SIZE-1:0] in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_SIZE-1:0] out_op,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err,
  output logic               busy
);
  localparam int PW   = $clog2(MAX_INFLIGHT);
  localparam int OW   = $clog2(MAX_INFLIGHT + 1);
  localparam int LM0  = LAT_ADD > LAT_MUL ? LAT_ADD : LAT_MUL;
  localparam int LM1  = LAT_DIV > LAT_CONV ? LAT_DIV : LAT_CONV;
  localparam int LMAX = LM0 > LM1 ? LM0 : LM1;
  localparam int CW   = $clog2(LMAX + 1);

  logic [OP_SIZE-1:0] r_op  [MAX_INFLIGHT];
  logic [TAG_W-1:0]   r_tag [MAX_INFLIGHT];
  logic               r_err [MAX_INFLIGHT];
  logic [CW-1:0]      r_cnt [MAX_INFLIGHT];
  logic [PW-1:0]      r_head, r_tail;
  logic [OW-1:0]      r_occ;

  logic          w_acc, w_ret, w_is_add, w_is_mul, w_is_div, w_is_conv, w_err;
  logic [CW-1:0] w_cnt;
  logic [PW-1:0] w_head_nx, w_tail_nx;

  assign w_is_add = in_op == OP_SIZE'(0) || in_op == OP_SIZE'(1);
  assign w_is_mul = in_op == OP_SIZE'(2);
  assign w_is_div = in_op == OP_SIZE'(3);
`ifdef FLOAT_CONV_EN
  assign w_is_conv = in_op == OP_SIZE'(4) || in_op == OP_SIZE'(5);
`else
  assign w_is_conv = 1'b0;
`endif
  assign w_err = !(w_is_add || w_is_mul || w_is_div || w_is_conv);
  // Stored count is latency-1: the accept edge itself counts as the first cycle.
  assign w_cnt = w_is_add  ? CW'(LAT_ADD - 1)  :
                 w_is_mul  ? CW'(LAT_MUL - 1)  :
                 w_is_div  ? CW'(LAT_DIV - 1)  :
                 w_is_conv ? CW'(LAT_CONV - 1) : '0;

  assign in_ready  = r_occ < OW'(MAX_INFLIGHT);
  assign busy      = r_occ != '0;
  assign out_valid = busy && r_cnt[r_head] == '0;
  assign out_op    = out_valid ? r_op[r_head]  : '0;
  assign out_tag   = out_valid ? r_tag[r_head] : '0;
  assign out_err   = out_valid ? r_err[r_head] : 1'b0;
  assign w_acc     = in_valid && in_ready;
  assign w_ret     = out_valid && out_ready;
  assign w_head_nx = r_head == PW'(MAX_INFLIGHT - 1) ? '0 : r_head + 1'b1;
  assign w_tail_nx = r_tail == PW'(MAX_INFLIGHT - 1) ? '0 : r_tail + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        r_op[i]  <= '0;
        r_tag[i] <= '0;
        r_err[i] <= 1'b0;
        r_cnt[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      for (int i = 0; i < MAX_INFLIGHT; i++)
        r_cnt[i] <= r_cnt[i] != '0 ? r_cnt[i] - 1'b1 : '0;
      if (w_acc) begin
        r_op[r_tail]  <= in_op;
        r_tag[r_tail] <= in_tag;
        r_err[r_tail] <= w_err;
        r_cnt[r_tail] <= w_cnt;
        r_tail        <= w_tail_nx;
      end
      if (w_ret)
        r_head <= w_head_nx;
      r_occ <= r_occ + OW'(w_acc) - OW'(w_ret);
    end
  end
endmodule
